// File: rtl/adr_sequencer.sv
// Purpose : issues a strided address sequence to a downstream cache, one access per accepted handshake.
// Latency : adr presents base_adr the cycle after start; each accepted transfer advances adr on the next edge.
// Backpr. : ready=0 holds adr/acc_count; the sequence stalls without losing or repeating an access.
//
// Ports:
//   clk, rst             - single rising-edge clock, asynchronous active-high reset
//   start                - one-cycle request; honoured only in IDLE or DONE
//   base_adr/stride/num_acc - sequence parameters, captured on the start edge only
//   ready                - downstream accepts adr this cycle
//   adr, adr_valid       - current request address and its valid flag
//   busy, done           - sequence running / finished (done held until next start)
//   acc_count            - accesses accepted in the current sequence
module adr_sequencer #(
    parameter int ADR_W = 15,
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADR_W-1:0] base_adr,
    input  logic [3:0]       stride,
    input  logic [CNT_W-1:0] num_acc,
    input  logic             ready,
    output logic [ADR_W-1:0] adr,
    output logic             adr_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] acc_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       stride_q;
    logic [CNT_W-1:0] num_q;

    logic [CNT_W-1:0] acc_inc;
    logic [ADR_W-1:0] adr_inc;

    // Address arithmetic wraps naturally at 2^ADR_W by truncation.
    assign acc_inc = acc_count + 1'b1;
    assign adr_inc = adr + {{(ADR_W-4){1'b0}}, stride_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stride_q  <= '0;
            num_q     <= '0;
            adr       <= '0;
            adr_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        stride_q  <= stride;
                        num_q     <= num_acc;
                        adr       <= base_adr;
                        acc_count <= '0;
                        if (num_acc == '0) begin
                            // Empty sequence completes immediately without issuing a request.
                            state     <= DONE;
                            done      <= 1'b1;
                            adr_valid <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            state     <= RUN;
                            done      <= 1'b0;
                            adr_valid <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    if (ready) begin
                        adr       <= adr_inc;
                        acc_count <= acc_inc;
                        if (acc_inc == num_q) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            adr_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    adr_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adr_sequencer.sv
// Purpose : directed bench for adr_sequencer with an address scoreboard.
// Latency : expected addresses queued at start, consumed on each observed handshake.
// Backpr. : ready driven per step; a stalled cycle consumes nothing from the queue.
module tb_adr_sequencer;

    localparam int ADR_W = 15;
    localparam int CNT_W = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ADR_W-1:0] base_adr;
    logic [3:0]       stride;
    logic [CNT_W-1:0] num_acc;
    logic             ready;
    logic [ADR_W-1:0] adr;
    logic             adr_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] acc_count;

    int n_assert = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    logic [ADR_W-1:0] exp_q[$];

    adr_sequencer #(.ADR_W(ADR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_adr  (base_adr),
        .stride    (stride),
        .num_acc   (num_acc),
        .ready     (ready),
        .adr       (adr),
        .adr_valid (adr_valid),
        .busy      (busy),
        .done      (done),
        .acc_count (acc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; handshakes are judged 1 time unit later.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b0 && adr_valid === 1'b1 && ready === 1'b1) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 32'(adr), 32'hFFFF_FFFF);
                end else begin
                    chk("xfer_adr", 32'(adr), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic do_start(input int b, input int s, input int n);
        @(negedge clk);
        start    = 1'b1;
        base_adr = ADR_W'(b);
        stride   = 4'(s);
        num_acc  = CNT_W'(n);
        for (int i = 0; i < n; i++) exp_q.push_back(ADR_W'(b + i * s));
        #2;
    endtask

    task automatic step(input logic st, input logic rdy);
        @(negedge clk);
        start = st;
        ready = rdy;
        #2;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            step(1'b0, ready);
            cycles++;
        end
        chk("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_adr"}, 32'(adr), 32'd0);
        chk({tag, "_adr_valid"}, 32'(adr_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_acc_count"}, 32'(acc_count), 32'd0);
    endtask

    initial begin
        #500000;
        n_assert++;
        n_fail++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        logic [1:0] rdy_pat [5];
        int         adr_pat [5];
        rst = 1'b1; start = 1'b0; base_adr = '0; stride = '0; num_acc = '0; ready = 1'b1;

        // Reset state, with start pulsed while reset is held.
        step(1'b1, 1'b1);
        base_adr = 15'd300; num_acc = 14'd5; stride = 4'd1;
        step(1'b1, 1'b1);
        chk_idle_outs("reset");
        step(1'b0, 1'b1);
        rst = 1'b0;
        step(1'b0, 1'b1);
        chk_idle_outs("post_reset_idle");

        // Long run: 8192 consecutive accesses from 1024.
        do_start(1024, 1, 8192);
        step(1'b0, 1'b1);
        chk("long_first_adr", 32'(adr), 32'd1024);
        chk("long_busy", 32'(busy), 32'd1);
        chk("long_valid", 32'(adr_valid), 32'd1);
        wait_done(9000, cyc);
        chk("long_cycles", 32'(cyc), 32'd8192);
        chk("long_xfers", 32'(n_xfer), 32'd8192);
        chk("long_acc_count", 32'(acc_count), 32'd8192);
        chk("long_valid_drop", 32'(adr_valid), 32'd0);
        chk("long_busy_drop", 32'(busy), 32'd0);
        chk("long_q_empty", 32'(exp_q.size()), 32'd0);

        // Address wrap at the top of the space.
        do_start(32766, 1, 4);
        step(1'b0, 1'b1);
        chk("wrap_first_adr", 32'(adr), 32'd32766);
        chk("wrap_done_cleared", 32'(done), 32'd0);
        wait_done(20, cyc);
        chk("wrap_acc_count", 32'(acc_count), 32'd4);
        chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: ready 1,0,0,1,1 with stride 4.
        rdy_pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
        adr_pat = '{100, 104, 104, 104, 108};
        do_start(100, 4, 3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, rdy_pat[i][0]);
            chk($sformatf("bp_adr_%0d", i), 32'(adr), 32'(adr_pat[i]));
            if (i == 2) chk("bp_hold_count", 32'(acc_count), 32'd1);
        end
        step(1'b0, 1'b1);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_acc_count", 32'(acc_count), 32'd3);
        chk("bp_valid_drop", 32'(adr_valid), 32'd0);
        step(1'b0, 1'b1);
        chk("bp_final_adr_held", 32'(adr), 32'd112);

        // Zero-length sequence.
        do_start(500, 1, 0);
        step(1'b0, 1'b1);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_valid", 32'(adr_valid), 32'd0);
        chk("zero_acc_count", 32'(acc_count), 32'd0);
        step(1'b0, 1'b1);
        chk("zero_valid_later", 32'(adr_valid), 32'd0);
        chk("zero_busy_later", 32'(busy), 32'd0);

        // Restart from DONE with new parameters.
        do_start(2048, 1, 2);
        step(1'b0, 1'b1);
        chk("restart_done_cleared", 32'(done), 32'd0);
        chk("restart_first_adr", 32'(adr), 32'd2048);
        wait_done(10, cyc);
        chk("restart_acc_count", 32'(acc_count), 32'd2);
        chk("restart_q_empty", 32'(exp_q.size()), 32'd0);

        // Start ignored mid-run, then asynchronous reset with acc_count=5.
        do_start(200, 2, 20);
        step(1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1; base_adr = 15'd7000; stride = 4'd7; num_acc = 14'd3;
        #2;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("midrun_acc_count", 32'(acc_count), 32'd5);
        chk("midrun_adr", 32'(adr), 32'd210);
        chk("midrun_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_idle_outs("async_reset");
        exp_q.delete();
        step(1'b0, 1'b1);
        rst = 1'b0;
        step(1'b0, 1'b1);
        chk_idle_outs("after_async_reset");

        // First start after reset runs normally.
        do_start(10, 3, 2);
        step(1'b0, 1'b1);
        chk("post_reset_first_adr", 32'(adr), 32'd10);
        wait_done(10, cyc);
        chk("post_reset_acc_count", 32'(acc_count), 32'd2);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
